uart_tx: RTL and testbench
==========================

# uart_tx

Byte-wide UART transmitter: serialises 8-bit bytes onto a single line as 8N1 frames (start bit, 8 data bits LSB first, STOP_BITS stop bits) at a fixed baud set by a clock divisor. A one-entry holding register lets the next byte be queued during a frame, so back-to-back frames go out with no idle gap. It sits between on-chip logic producing bytes and the board TX pin, and uses the same framing and default baud (115200 at 50 MHz) as the team's receiver.

## Interface
- CLKS_PER_BIT, 434: clock cycles per bit period (50 MHz / 115200); legal range 2..65535.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- CLK  input  1  system clock; all logic on the rising edge.
- RST_N  input  1  reset; synchronous and active-low.
- TX_DATA  input  8  byte to send; sampled when TX_VALID && TX_READY.
- TX_VALID  input  1  producer has a byte on TX_DATA.
- TX_READY  output  1  holding register empty; a byte is accepted on any edge where TX_VALID && TX_READY.
- TX_OUT  output  1  serial line; idle high; registered.
- BUSY  output  1  high while a frame is on the line (start bit through last stop-bit cycle).
- DONE  output  1  one-cycle pulse on frame completion.

## Operation
- Reset (RST_N low at an edge): TX_OUT=1, BUSY=0, DONE=0, holding register empty, state IDLE, counters 0. TX_READY is forced 0 while RST_N is low and is 1 on the first cycle after release.
- Reset mid-frame aborts the frame. TX_OUT returns high at that edge and any queued byte is discarded.
- Holding register: written on accept. It is emptied when the shifter loads from it. TX_READY = !hold_full (while out of reset).
- States: IDLE, START, DATA, STOP.
  - IDLE: TX_OUT=1. If hold_full, load the shifter, clear hold_full, go to START.
  - START: TX_OUT=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: TX_OUT=shift[0]. Every CLKS_PER_BIT cycles, shift right and increment the bit index. After bit 7's period, go to STOP.
  - STOP: TX_OUT=1 for STOP_BITS*CLKS_PER_BIT cycles. At the end of this period, pulse DONE.
    - If hold_full, load the shifter and go directly to START (no idle cycle).
    - Otherwise go to IDLE.
- Baud counter width: $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, and the bit boundary is at count == CLKS_PER_BIT-1. The bit index is 3 bits and does not wrap past 7.
- TX_DATA changes while TX_READY=0 are ignored. A byte is never dropped or duplicated.

## Timing
- Accept at edge E0 (shifter idle): TX_OUT falls at E1. BUSY rises at E1. TX_READY is low for exactly one cycle (E0→E1).
- Each bit is exactly CLKS_PER_BIT cycles. A frame is (9+STOP_BITS)*CLKS_PER_BIT cycles from the falling edge of the start bit to the end of the stop bit.
- DONE is high for the one cycle following the final stop-bit cycle. BUSY falls on the same edge, unless a queued byte starts.
  - In the back-to-back case, DONE=1, BUSY stays 1, and TX_OUT=0 (next start bit) in the same cycle.
- A second byte may be accepted any time after E1 of the current frame. It starts immediately after the current stop period.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP);
  - DATA_BITS=8;
  - default CLK_FREQ=50_000_000, BAUD=115200 and the derived CLKS_PER_BIT.
- One natural sub-module: uart_baud_cnt, a parameterised divider with a clear input and a one-cycle tick output at count CLKS_PER_BIT-1. The receiver may reuse it later.

## Test plan
Bench uses CLKS_PER_BIT=4.
- Single byte: after reset, send 0xA5 → TX_OUT = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. DONE pulses once, 40 cycles after TX_OUT falls. BUSY is high for exactly 40 cycles.
- Back-to-back: send 0x00, then 0xFF while the first frame is in progress → 80 contiguous cycles (start, 8×0, stop, start, 8×1, stop) with no idle cycle between. DONE pulses at cycles 40 and 80.
- Backpressure: hold TX_VALID=1 with 0x3C, then 0x55 and 0x66 → TX_READY low while hold is full. 0x66 is only accepted after 0x55 moves to the shifter. Output bytes are exactly 0x3C, 0x55, 0x66 in order.
- Reset mid-frame: drop RST_N during data bit 3 of 0xF0 → TX_OUT=1, BUSY=0, DONE=0 at that edge. After release, no residual frame. A new byte 0x81 then transmits correctly.
- STOP_BITS=2: send 0x01 → stop period of 8 high cycles, frame of 44 cycles. DONE occurs at cycle 44.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame width and the default baud divisor.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int DATA_BITS    = 8;
  localparam int CLK_FREQ     = 50_000_000;
  localparam int BAUD         = 115_200;
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and ticks on the last count of each period.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear || r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_tick = (r_count == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register for gap-free back-to-back frames.
module uart_tx #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       TX_OUT,
  output logic       BUSY,
  output logic       DONE
);
  import uart_pkg::*;

  uart_state_t          r_state;
  logic [DATA_BITS-1:0] r_hold;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_hold_full;
  logic [2:0]           r_bit_idx;
  logic                 r_stop_cnt;
  logic                 r_tx_out;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_tick;
  logic                 w_clear;
  logic                 w_accept;

  // Holding the divider at zero while idle makes the start bit a full period long.
  assign w_clear  = (r_state == IDLE);
  assign TX_READY = RST_N && !r_hold_full;
  assign w_accept = TX_VALID && TX_READY;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk  (CLK),
    .i_rst_n(RST_N),
    .i_clear(w_clear),
    .o_tick (w_tick)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_stop_cnt  <= 1'b0;
      r_tx_out    <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_hold      <= TX_DATA;
        r_hold_full <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          r_tx_out <= 1'b1;
          if (r_hold_full) begin
            r_shift     <= r_hold;
            r_hold_full <= 1'b0;
            r_tx_out    <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= START;
          end
        end
        START: begin
          if (w_tick) begin
            r_state   <= DATA;
            r_bit_idx <= '0;
            r_tx_out  <= r_shift[0];
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bit_idx == 3'(DATA_BITS - 1)) begin
              r_state    <= STOP;
              r_stop_cnt <= 1'b0;
              r_tx_out   <= 1'b1;
            end else begin
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx_out  <= r_shift[1];
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
              r_done <= 1'b1;
              // A queued byte starts its start bit on the very edge this frame ends.
              if (r_hold_full) begin
                r_shift     <= r_hold;
                r_hold_full <= 1'b0;
                r_tx_out    <= 1'b0;
                r_state     <= START;
              end else begin
                r_tx_out <= 1'b1;
                r_busy   <= 1'b0;
                r_state  <= IDLE;
              end
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign TX_OUT = r_tx_out;
  assign BUSY   = r_busy;
  assign DONE   = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: one instance per stop-bit setting, each with its own stimulus and line monitor.
module tb_uart_tx;

  localparam int N = 4;

  typedef struct {
    logic [7:0] data;
    int         acc;
    int         start;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int SB = gi + 1;
    localparam int F  = (9 + SB) * N;

    logic       rst_n    = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_out;
    logic       busy;
    logic       done;
    bit         fin = 1'b0;

    exp_t exp_q[$];
    int   last_end = 0;

    bit         in_frame = 1'b0;
    bit         frame_ready = 1'b0;
    bit         frame_ok = 1'b0;
    int         fs = 0;
    int         frame_fs = 0;
    logic [7:0] frame_byte = 8'h00;
    logic       samp [0:63];

    uart_tx #(
      .CLKS_PER_BIT(N),
      .STOP_BITS   (SB)
    ) u_dut (
      .CLK     (clk),
      .RST_N   (rst_n),
      .TX_DATA (tx_data),
      .TX_VALID(tx_valid),
      .TX_READY(tx_ready),
      .TX_OUT  (tx_out),
      .BUSY    (busy),
      .DONE    (done)
    );

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] x);
      check($sformatf("sb%0d_%s", SB, nm), a, x);
    endtask

    // Expected line schedule: a frame starts the cycle after its accept, or when the previous frame ends.
    task automatic send(input logic [7:0] b, output int st);
      int waited = 0;
      tx_valid = 1'b1;
      tx_data  = b;
      while (!tx_ready && waited < 400) begin
        @(negedge clk);
        waited++;
      end
      if (!tx_ready) begin
        chk("ready_timeout", tx_ready, 1);
        tx_valid = 1'b0;
        st = -1;
        return;
      end
      st = (cyc + 2 > last_end) ? cyc + 2 : last_end;
      exp_q.push_back('{b, cyc + 1, st});
      last_end = st + F;
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
    endtask

    task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 2000) begin
        @(negedge clk);
        n++;
      end
      chk("drain", exp_q.size(), 0);
      repeat (3) @(negedge clk);
    endtask

    always @(posedge clk) begin : mon
      int   e;
      bit   exp_busy;
      bit   exp_ready;
      bit   exp_done;
      bit   ok;
      exp_t x;
      #1;
      e = cyc;
      if (!rst_n) begin
        chk("rst_tx", tx_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", tx_ready, 0);
        exp_q.delete();
        last_end    = 0;
        in_frame    = 1'b0;
        frame_ready = 1'b0;
      end else begin
        if (in_frame) begin
          samp[e - fs] = tx_out;
          if (e - fs == F - 1) begin
            ok = (samp[0] == 1'b0);
            for (int b = 0; b < 9 + SB; b++) begin
              for (int j = 0; j < N; j++) begin
                if (samp[b*N + j] !== samp[b*N]) ok = 1'b0;
              end
            end
            for (int b = 9; b < 9 + SB; b++) begin
              if (samp[b*N] !== 1'b1) ok = 1'b0;
            end
            for (int i = 0; i < 8; i++) frame_byte[i] = samp[(1 + i)*N + N/2];
            frame_ok    = ok;
            frame_fs    = fs;
            frame_ready = 1'b1;
            in_frame    = 1'b0;
          end
        end else if (tx_out === 1'b0) begin
          in_frame = 1'b1;
          fs       = e;
          samp[0]  = 1'b0;
        end

        exp_busy  = 1'b0;
        exp_ready = 1'b1;
        exp_done  = 1'b0;
        foreach (exp_q[k]) begin
          if (exp_q[k].start <= e && e < exp_q[k].start + F) exp_busy = 1'b1;
          if (exp_q[k].acc <= e && e < exp_q[k].start) exp_ready = 1'b0;
          if (exp_q[k].start + F == e) exp_done = 1'b1;
        end
        chk("busy", busy, exp_busy);
        chk("ready", tx_ready, exp_ready);
        chk("done", done, exp_done);

        if (done === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("spurious_done", done, 0);
          end else begin
            x = exp_q.pop_front();
            chk("done_time", e, x.start + F);
            chk("frame_seen", frame_ready, 1);
            chk("start_time", frame_fs, x.start);
            chk("frame_shape", frame_ok, 1);
            chk("data", frame_byte, x.data);
            $display("sb%0d frame: exp=%02h got=%02h start=%0d done=%0d", SB, x.data, frame_byte, frame_fs, e);
            frame_ready = 1'b0;
          end
        end
      end
    end

    initial begin : stim
      int st;
      int s0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      send(8'hA5, st);
      wait_idle();
      send(8'h00, st);
      send(8'hFF, st);
      wait_idle();
      send(8'h3C, st);
      send(8'h55, st);
      send(8'h66, st);
      wait_idle();
      send(8'h01, st);
      wait_idle();

      for (int k = 0; k < 16; k++) begin
        send(8'($urandom), st);
        repeat ($urandom_range(0, F + 4)) @(negedge clk);
      end
      wait_idle();

      // Abort during data bit 3 with a second byte queued; neither may reach the line.
      send(8'hF0, s0);
      send(8'h12, st);
      while (cyc < s0 + 4*N + 1) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (F + 10) @(negedge clk);
      send(8'h81, st);
      wait_idle();
      fin = 1'b1;
    end
  end

  initial begin : top
    int n = 0;
    while (!(g_inst[0].fin && g_inst[1].fin) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("test_timeout", g_inst[0].fin && g_inst[1].fin, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
